// File: rtl/bus_arb.sv
// bus_arb: shares one external memory bus between the fetch read port and the
// MEM-stage read/write port. Completed results are held until the owning stage
// advances, so a stalled stage never reissues a bus op. An optional watchdog
// aborts a transaction when m_ack never arrives.
module bus_arb #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_rd_req,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic                  i_adv,
  output logic [DATA_W-1:0]     i_data,
  output logic                  i_busy,
  input  logic                  d_rd_req,
  input  logic                  d_wr_req,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_be,
  input  logic                  d_adv,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_busy_rd,
  output logic                  d_busy_wr,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_be,
  output logic                  m_rd,
  output logic                  m_wr,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic                  m_ack,
  output logic                  err
);

  localparam int unsigned BE_W     = DATA_W / 8;
  localparam int unsigned CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : CNT_W'(0);
  localparam bit          WDOG_EN  = (TIMEOUT != 0);

  typedef enum logic [1:0] {S_IDLE, S_I_BUS, S_D_BUS} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             i_done_q, d_done_q;
  logic             i_fin_q, d_fin_q;
  logic             i_pend, d_pend;
  logic             expire, op_end;
  logic             m_rd_nx, m_wr_nx, err_nx;
  logic             ld_i, ld_d, i_cap, d_cap;

  // A port is eligible when it requests, has no held result and is not in its capture cycle
  assign i_pend = i_rd_req && !i_done_q && !i_fin_q;
  assign d_pend = (d_rd_req || d_wr_req) && !d_done_q && !d_fin_q;

  // Watchdog expiry; an m_ack in the same cycle takes precedence
  assign expire = WDOG_EN && (state_q != S_IDLE) && !m_ack && (cnt_q == CNT_W'(0));
  assign op_end = m_ack || expire;

  // Busy flags go straight to the control unit
  assign i_busy    = i_rd_req && !i_done_q;
  assign d_busy_rd = d_rd_req && !d_wr_req && !d_done_q;
  assign d_busy_wr = d_wr_req && !d_done_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: data port wins ties since it holds the older instruction
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (d_pend)      state_d = S_D_BUS;
        else if (i_pend) state_d = S_I_BUS;
      end
      S_I_BUS, S_D_BUS: begin
        if (op_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: next strobe values, bus loads and result captures
  always_comb begin
    m_rd_nx = 1'b0;
    m_wr_nx = 1'b0;
    err_nx  = 1'b0;
    ld_i    = 1'b0;
    ld_d    = 1'b0;
    i_cap   = 1'b0;
    d_cap   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (state_d == S_D_BUS) begin
          ld_d    = 1'b1;
          m_rd_nx = !d_wr_req;
          m_wr_nx = d_wr_req;
        end else if (state_d == S_I_BUS) begin
          ld_i    = 1'b1;
          m_rd_nx = 1'b1;
        end
      end
      S_I_BUS: begin
        if (op_end) begin
          i_cap  = 1'b1;
          err_nx = expire;
        end else begin
          m_rd_nx = m_rd;
        end
      end
      S_D_BUS: begin
        if (op_end) begin
          d_cap  = 1'b1;
          err_nx = expire;
        end else begin
          m_rd_nx = m_rd;
          m_wr_nx = m_wr;
        end
      end
      default: ;
    endcase
  end

  // Bus-side registers and watchdog counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_addr  <= '0;
      m_wdata <= '0;
      m_be    <= '0;
      m_rd    <= 1'b0;
      m_wr    <= 1'b0;
      err     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      m_rd <= m_rd_nx;
      m_wr <= m_wr_nx;
      err  <= err_nx;
      if (ld_i) begin
        m_addr  <= i_addr;
        m_wdata <= '0;
        m_be    <= {BE_W{1'b1}};
      end else if (ld_d) begin
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
        m_be    <= d_be;
      end
      if (ld_i || ld_d) begin
        cnt_q <= CNT_LOAD;
      end else if ((state_q != S_IDLE) && !m_ack && (cnt_q != CNT_W'(0))) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Result capture and done flags; done is raised one cycle after the bus op ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_data   <= '0;
      d_rdata  <= '0;
      i_fin_q  <= 1'b0;
      d_fin_q  <= 1'b0;
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
    end else begin
      i_fin_q <= i_cap;
      d_fin_q <= d_cap;
      if (i_cap) i_data <= m_ack ? m_rdata : '0;
      if (d_cap) begin
        if (!m_ack)    d_rdata <= '0;
        else if (m_rd) d_rdata <= m_rdata;
      end
      if (i_fin_q)                   i_done_q <= 1'b1;
      else if (i_adv || !i_rd_req)   i_done_q <= 1'b0;
      if (d_fin_q)                               d_done_q <= 1'b1;
      else if (d_adv || !(d_rd_req || d_wr_req)) d_done_q <= 1'b0;
    end
  end

endmodule
